// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: fetch FSM states and instruction field constants shared by fetch and decode.
package fetch_stage_pkg;
    typedef enum logic [1:0] {FETCH, HELD, DISCARD} fetch_state_e;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if;
    import fetch_stage_pkg::*;
    logic               imem_req;
    logic [31:0]        imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_valid;
    modport master (output imem_req, imem_addr, input imem_rdata, imem_valid);
    modport slave  (input imem_req, imem_addr, output imem_rdata, imem_valid);
endinterface

// File: rtl/fetch_stage_if_id.sv
// if_id_reg: IF/ID pipeline register; clear beats load, otherwise the contents hold.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [31:0]        pc_plus4_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [31:0]        pc_plus4_o,
    output logic               valid_o
);
    logic [INSTR_W-1:0] instr_q;
    logic [31:0]        pc_plus4_q;
    logic               valid_q;

    // A clear keeps pc_plus4 so a later jump still sees a defined region.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (clear_i) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q    <= instr_i;
            pc_plus4_q <= pc_plus4_i;
            valid_q    <= 1'b1;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage and IF/ID register over a variable-latency imem handshake.
// Define FETCH_PERF_CNT_EN to add the perf_fetched/perf_stall counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    fetch_stage_if.master      imem,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               jump,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [31:0]        if_id_pc_plus4,
    output logic               if_id_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall,
`endif
    output logic [5:0]         opcode
);
    fetch_state_e       state_q, state_d;
    logic [31:0]        req_addr_q, req_addr_d, tgt_q, tgt_d, target;
    logic [INSTR_W-1:0] hold_q, hold_d, load_instr;
    logic               redirect, load, clear;

    assign redirect = branch_taken | jump;
    // The branch is older than the jump sitting in decode, so it wins.
    assign target = branch_taken ? branch_target : {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00};
    assign imem.imem_req  = !rst && (state_q != HELD);
    assign imem.imem_addr = req_addr_q;
    assign opcode = if_id_instr[OPC_MSB:OPC_LSB];

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        tgt_d      = tgt_q;
        hold_d     = hold_q;
        load       = 1'b0;
        clear      = 1'b0;
        load_instr = imem.imem_rdata;
        if (redirect) begin
            clear      = 1'b1;
            tgt_d      = target;
            hold_d     = NOP_INSTR;
            state_d    = (state_q == HELD || imem.imem_valid) ? FETCH : DISCARD;
            req_addr_d = (state_q == HELD || imem.imem_valid) ? target : req_addr_q;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem.imem_valid && stall) begin
                        hold_d  = imem.imem_rdata;
                        state_d = HELD;
                    end else if (imem.imem_valid) begin
                        load       = 1'b1;
                        req_addr_d = req_addr_q + 32'd4;
                    end else begin
                        // No word this cycle: decode sees a bubble unless it is stalled.
                        clear = !stall;
                    end
                end
                HELD: begin
                    if (!stall) begin
                        load       = 1'b1;
                        load_instr = hold_q;
                        hold_d     = NOP_INSTR;
                        req_addr_d = req_addr_q + 32'd4;
                        state_d    = FETCH;
                    end
                end
                DISCARD: begin
                    clear = 1'b1;
                    if (imem.imem_valid) begin
                        req_addr_d = tgt_q;
                        state_d    = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            req_addr_q <= RESET_PC;
            tgt_q      <= RESET_PC;
            hold_q     <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            tgt_q      <= tgt_d;
            hold_q     <= hold_d;
        end
    end

    if_id_reg u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .clear_i    (clear),
        .instr_i    (load_instr),
        .pc_plus4_i (req_addr_q + 32'd4),
        .instr_o    (if_id_instr),
        .pc_plus4_o (if_id_pc_plus4),
        .valid_o    (if_id_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_q + {31'd0, load};
            perf_stall_q   <= perf_stall_q + {31'd0, stall && if_id_valid};
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed fetch scenarios, then random traffic checked against a program-order model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] if_id_instr, if_id_pc_plus4;
    logic        if_id_valid;
    logic [5:0]  opcode;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall;
`endif
    int checks = 0, errors = 0;
    int fix_lat = 0, cnt = 0, cur_lat = 0, delivered = 0;
    bit rand_mode = 1'b0, started = 1'b0, exp_bub = 1'b0;
    logic [31:0] exp_pc, pc4, w;

    fetch_stage_if bus();

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (bus),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
`endif
        .opcode         (opcode)
    );

    // Program image: address-scrambled words, with one jump planted at 0x4000_000C.
    function automatic logic [31:0] word(input logic [31:0] a);
        return (a == 32'h4000_000C) ? 32'h0800_0040 : ({a[15:0], a[31:16]} ^ 32'hA5C3_0F1E);
    endfunction

    // Memory responder: answers each request after cur_lat wait cycles; babbles during reset.
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            started = 1'b0;
            bus.imem_valid = 1'b1;
            bus.imem_rdata = 32'hDEAD_BEEF;
        end else if (!bus.imem_req) begin
            started = 1'b0;
            bus.imem_valid = 1'b0;
        end else begin
            if (!started || bus.imem_valid) begin
                started = 1'b1;
                cnt = 0;
                cur_lat = rand_mode ? int'($urandom_range(0, 2)) : fix_lat;
            end else begin
                cnt++;
            end
            bus.imem_valid = (cnt >= cur_lat);
            bus.imem_rdata = word(bus.imem_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    initial begin
        @(negedge clk);
        tick();
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_instr", if_id_instr, 32'd0);
        chk("rst_pc4", if_id_pc_plus4, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_f", perf_fetched, 32'd0);
        chk("rst_perf_s", perf_stall, 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("first_req", {31'd0, bus.imem_req}, 32'd1);
        chk("first_addr", bus.imem_addr, 32'd0);
        for (int i = 1; i <= 2; i++) begin
            tick();
            chk("seq_addr", bus.imem_addr, 32'(4 * i));
            chk("seq_pc4", if_id_pc_plus4, 32'(4 * i));
            chk("seq_valid", {31'd0, if_id_valid}, 32'd1);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("held_req", {31'd0, bus.imem_req}, 32'd0);
            chk("held_pc4", if_id_pc_plus4, 32'h8);
        end
        stall = 1'b0;
        tick();
        chk("rel_instr", if_id_instr, word(32'h8));
        chk("rel_pc4", if_id_pc_plus4, 32'hC);
        chk("rel_addr", bus.imem_addr, 32'hC);
        chk("rel_req", {31'd0, bus.imem_req}, 32'd1);
        fix_lat = 2;
        branch_taken = 1'b1;
        branch_target = 32'h100;
        tick();
        branch_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("disc_valid", {31'd0, if_id_valid}, 32'd0);
            chk("disc_addr", bus.imem_addr, 32'hC);
            tick();
        end
        chk("disc_tgt_addr", bus.imem_addr, 32'h100);
        chk("disc_tgt_valid", {31'd0, if_id_valid}, 32'd0);
        fix_lat = 0;
        tick();
        chk("br_valid", {31'd0, if_id_valid}, 32'd1);
        chk("br_pc4", if_id_pc_plus4, 32'h104);
        chk("br_instr", if_id_instr, word(32'h100));
        branch_taken = 1'b1;
        branch_target = 32'h4000_000C;
        tick();
        branch_taken = 1'b0;
        chk("j_pre_addr", bus.imem_addr, 32'h4000_000C);
        tick();
        chk("j_pc4", if_id_pc_plus4, 32'h4000_0010);
        chk("j_opcode", {26'd0, opcode}, 32'h2);
        jump = 1'b1;
        tick();
        jump = 1'b0;
        chk("j_addr", bus.imem_addr, 32'h4000_0100);
        chk("j_bubble", {31'd0, if_id_valid}, 32'd0);
        tick();
        chk("j_valid", {31'd0, if_id_valid}, 32'd1);
        chk("j_tgt_pc4", if_id_pc_plus4, 32'h4000_0104);
        branch_taken = 1'b1;
        jump = 1'b1;
        stall = 1'b1;
        branch_target = 32'h200;
        tick();
        branch_taken = 1'b0;
        jump = 1'b0;
        stall = 1'b0;
        chk("all3_addr", bus.imem_addr, 32'h200);
        chk("all3_valid", {31'd0, if_id_valid}, 32'd0);
        chk("all3_instr", if_id_instr, 32'd0);
        tick();
        chk("all3_pc4", if_id_pc_plus4, 32'h204);
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc4", if_id_pc_plus4, 32'h0);
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("wrap_instr", if_id_instr, word(32'hFFFF_FFFC));
        fix_lat = 2;
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("mid_rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("mid_rst_pc4", if_id_pc_plus4, 32'd0);
        chk("mid_rst_addr", bus.imem_addr, 32'd0);
        fix_lat = 0;
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("restart_pc4", if_id_pc_plus4, 32'(4 * i));
        end
        stall = 1'b1;
        repeat (4) tick();
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, 32'd10);
        chk("perf_stall", perf_stall, 32'd4);
`endif
        stall = 1'b0;
        tick();
        chk("post_perf_pc4", if_id_pc_plus4, 32'd44);
        chk("post_perf_instr", if_id_instr, word(32'd40));

        // Random phase: exp_pc is the address of the next instruction decode must see.
        rand_mode = 1'b1;
        exp_pc = 32'd40;
        for (int n = 0; n < 3000; n++) begin
            if (exp_bub) chk("rnd_bubble", {31'd0, if_id_valid}, 32'd0);
            if (if_id_valid) begin
                chk("rnd_pc4", if_id_pc_plus4, exp_pc + 32'd4);
                chk("rnd_instr", if_id_instr, word(exp_pc));
            end
            stall = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 15) == 0);
            jump = if_id_valid && ($urandom_range(0, 11) == 0);
            branch_target = $urandom() & 32'hFFFF_FFFC;
            if (if_id_valid && !stall) delivered++;
            exp_bub = branch_taken | jump;
            pc4 = exp_pc + 32'd4;
            w = word(exp_pc);
            if (branch_taken) exp_pc = branch_target;
            else if (jump) exp_pc = {pc4[31:28], w[25:0], 2'b00};
            else if (if_id_valid && !stall) exp_pc = pc4;
            tick();
        end
        branch_taken = 1'b0;
        jump = 1'b0;
        stall = 1'b0;
        chk("rnd_progress", {31'd0, delivered > 300}, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the MIPS datapath: it holds the PC, requests instructions from instruction memory, and delivers the fetched word and PC+4 to decode. The `opcode` field of the IF/ID instruction drives the decode-stage control unit directly. Branch and jump redirects, and stalls from hazard logic, are applied here. A small FSM tolerates variable-latency instruction memory.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `imem_req`  out  1  fetch request; held until `imem_valid`
- `imem_addr`  out  32  byte address of requested word; stable while `imem_req`=1
- `imem_rdata`  in  32  instruction word, sampled when `imem_valid`=1
- `imem_valid`  in  1  one-cycle data-valid; meaningful only while `imem_req`=1 (same-cycle return allowed)
- `stall`  in  1  hazard unit: hold IF/ID and PC
- `branch_taken`  in  1  taken branch redirect
- `branch_target`  in  32  branch destination
- `jump`  in  1  jump in decode (control unit `jump` output)
- `if_id_instr`  out  32  registered instruction
- `if_id_pc_plus4`  out  32  registered PC+4 of that instruction
- `if_id_valid`  out  1  IF/ID holds a real instruction
- `opcode`  out  6  `if_id_instr[31:26]`, combinational

## Operation
- FSM states: `FETCH` (request outstanding), `HELD` (word buffered during stall), `DISCARD` (outstanding request is wrong-path).
- `FETCH`: `imem_req`=1, `imem_addr`=`req_addr`. On `imem_valid` with no stall/redirect: IF/ID <= {rdata, req_addr+4, valid=1}, `req_addr` += 4, stay in `FETCH`.
- `imem_valid` with `stall`=1 and no redirect: word and address go into the hold buffer; go to `HELD`. IF/ID is unchanged.
- `HELD`: `imem_req`=0. On `stall`=0: IF/ID <= buffer, `req_addr` += 4, go to `FETCH`.
- Redirect = `branch_taken` | `jump`. Branch wins when both are set, because the branch is older. Jump target = {`if_id_pc_plus4[31:28]`, `if_id_instr[25:0]`, 2'b00}.
- On redirect in any state: `if_id_valid` <= 0, `if_id_instr` <= 0, hold buffer dropped, target latched.
  - `imem_valid` same cycle, or state `HELD`: `req_addr` <= target, go to `FETCH`.
  - Request outstanding without valid: go to `DISCARD`.
- `DISCARD`: `imem_req` stays 1 at the old address. The returning word is dropped; then `req_addr` <= latched target, go to `FETCH`. A further redirect in `DISCARD` overwrites the latched target.
- Redirect beats stall. Stall without a word arriving keeps IF/ID and `req_addr` unchanged.
- Address arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0. Bits [1:0] of the target are not checked.

## Timing
- `rst`=1 during a clock edge sets:
  - `req_addr`=`RESET_PC`; state `FETCH`
  - `if_id_instr`=0, `if_id_pc_plus4`=0, `if_id_valid`=0
  - hold buffer empty; perf counters 0
- `imem_req`=0 while `rst`=1. From the first cycle after reset, `imem_req`=1 and `imem_addr`=`RESET_PC`.
- Reset mid-request: the outstanding request is abandoned. `imem_valid` during reset is ignored.
- Latency is one cycle from `imem_valid` to IF/ID. With zero-wait memory, throughput is one instruction per cycle.
- A redirect produces exactly one bubble in IF/ID with zero-wait memory, plus one extra bubble per wait cycle in `DISCARD`.

## Configuration
- `FETCH_PERF_CNT_EN` defined adds:
  - `perf_fetched` (out 32): counts words loaded into IF/ID with valid=1.
  - `perf_stall` (out 32): counts cycles with `stall`=1 and `if_id_valid`=1.
  - Both counters wrap modulo 2^32 and clear on reset.
- Undefined: no counter ports and no counter logic.

## Structure
- Shared package holds:
  - the FSM state enum (`FETCH`, `HELD`, `DISCARD`)
  - `NOP_INSTR`=32'h0 and `INSTR_W`=32
  - opcode field constants (`OPC_MSB`=31, `OPC_LSB`=26), reused by the control unit
- Sub-module `if_id_reg` holds the IF/ID register with load, hold and clear. FSM and PC logic stay in `fetch_stage`.

## Test plan
- Reset, zero-wait memory returning addr-based words -> `imem_addr` 0,4,8,12 on consecutive cycles; `if_id_pc_plus4` 4,8,12; `if_id_valid`=1 from cycle 2.
- `stall` for 3 cycles with word at 0x8 returning -> state `HELD` and `imem_req`=0 for 3 cycles. On release, IF/ID shows 0x8 word with pc_plus4 0xC, then fetch continues at 0xC.
- `branch_taken`, target 0x100, while memory waits 2 cycles -> `DISCARD`; old word dropped, `if_id_valid`=0 throughout, next `imem_addr`=0x100.
- `jump` with `if_id_pc_plus4`=0x4000_0010, instr[25:0]=0x40 -> next `imem_addr`=0x4000_0100; one bubble.
- `branch_taken` (0x200), `jump` and `stall` together -> fetch resumes at 0x200; IF/ID cleared.
- `rst` during an outstanding request, then `FETCH_PERF_CNT_EN` build with 10 fetches and 4 stall cycles -> fetch restarts at `RESET_PC`; `perf_fetched`=10, `perf_stall`=4.
